// File: rtl/lock_pkg.sv
// Shared definitions for the lock-chamber water-level engine and the door stage.
// Holds the water state enum, level/margin widths and the default pool/rate constants.
package lock_pkg;

    localparam int unsigned LEVEL_W     = 7;   // level in 0.1 ft units, 0..127
    localparam int unsigned DOOR_MARGIN = 3;   // 0.3 ft tolerance for door-safe flags
    localparam int unsigned PHASE_W     = 8;   // phase counter width, divisors up to 256
    localparam int unsigned ETA_W       = 10;  // remaining-time readout width, cmin units

    localparam int unsigned DEF_INNER     = 6;
    localparam int unsigned DEF_OUTER     = 4;
    localparam int unsigned DEF_RAISE_DIV = 16;
    localparam int unsigned DEF_LOWER_DIV = 14;

    typedef enum logic [1:0] {
        IDLE,
        RAISING,
        LOWERING,
        HOLD
    } water_state_t;

    // Counter width able to hold 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lock_rate_timer.sv
// Ramp-rate timer: prescaler producing a 1/100 minute tick and a phase counter that
// produces a step strobe every DIV ticks.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   run         advance the prescaler this cycle
//   clear       zero prescaler and phase (wins over run)
//   div_sel     0 = RAISE_DIV, 1 = LOWER_DIV
//   cmin_tick   prescaler wrap cycle
//   step        cmin_tick on which the phase is at DIV-1 (level moves by one unit)
module lock_rate_timer
    import lock_pkg::*;
#(
    parameter int unsigned TICKS_PER_CMIN = 3000,
    parameter int unsigned RAISE_DIV      = DEF_RAISE_DIV,
    parameter int unsigned LOWER_DIV      = DEF_LOWER_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    input  logic div_sel,
    output logic cmin_tick,
    output logic step
);

    localparam int unsigned PRESC_W = cnt_width(TICKS_PER_CMIN);
    localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(TICKS_PER_CMIN - 1);
    localparam logic [PHASE_W-1:0] RAISE_LAST = PHASE_W'(RAISE_DIV - 1);
    localparam logic [PHASE_W-1:0] LOWER_LAST = PHASE_W'(LOWER_DIV - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] phase_last;

    always_comb begin
        phase_last = div_sel ? LOWER_LAST : RAISE_LAST;
        cmin_tick  = run && !clear && (presc_q == PRESC_MAX);
        step       = cmin_tick && (phase_q == phase_last);
        presc_d    = presc_q;
        phase_d    = phase_q;
        if (clear) begin
            presc_d = '0;
            phase_d = '0;
        end else if (run) begin
            presc_d = cmin_tick ? '0 : presc_q + 1'b1;
            if (cmin_tick) begin
                phase_d = step ? '0 : phase_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            phase_q <= '0;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/lock_water_level.sv
// Lock-chamber water-level engine. Ramps the chamber level toward the inner or outer
// pool on request, freezes while a door is open, and publishes door-safe flags.
// Optional feature macro: LOCK_WATER_ETA_EN adds the registered eta_cmin output.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   raise_req    fill toward INNER*10
//   lower_req    drain toward OUTER*10 (both high while ramping aborts the ramp)
//   hold         a door is open; freeze level, phase and prescaler
//   level        current level, 0.1 ft units
//   outer_ok     level within DOOR_MARGIN of the outer pool
//   inner_ok     level within DOOR_MARGIN of the inner pool
//   moving       state is RAISING or LOWERING
//   done         one-cycle pulse when a ramp reaches its target
//   eta_cmin     (LOCK_WATER_ETA_EN only) remaining ramp time in 1/100 minute
module lock_water_level
    import lock_pkg::*;
#(
    parameter int unsigned INNER          = DEF_INNER,
    parameter int unsigned OUTER          = DEF_OUTER,
    parameter int unsigned INIT_LEVEL     = 40,
    parameter int unsigned TICKS_PER_CMIN = 3000,
    parameter int unsigned RAISE_DIV      = DEF_RAISE_DIV,
    parameter int unsigned LOWER_DIV      = DEF_LOWER_DIV
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               raise_req,
    input  logic               lower_req,
    input  logic               hold,
    output logic [LEVEL_W-1:0] level,
    output logic               outer_ok,
    output logic               inner_ok,
    output logic               moving,
    output logic               done
`ifdef LOCK_WATER_ETA_EN
    ,
    output logic [ETA_W-1:0]   eta_cmin
`endif
);

    localparam logic [LEVEL_W-1:0] RAISE_TGT    = LEVEL_W'(INNER * 10);
    localparam logic [LEVEL_W-1:0] LOWER_TGT    = LEVEL_W'(OUTER * 10);
    localparam logic [LEVEL_W-1:0] INIT_LVL     = LEVEL_W'(INIT_LEVEL);
    localparam logic [LEVEL_W-1:0] OUTER_OK_MAX = LEVEL_W'(OUTER * 10 + DOOR_MARGIN);
    localparam logic [LEVEL_W-1:0] INNER_OK_MIN = LEVEL_W'(INNER * 10 - DOOR_MARGIN);

    water_state_t       state_q, state_d;
    logic               dir_q, dir_d;      // ramp direction, 1 = lowering; kept through HOLD
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               done_q, done_d;
    logic               ramping, abort, run, clear;
    logic               cmin_tick, step;

    always_comb begin
        ramping = (state_q != IDLE);
        abort   = ramping && raise_req && lower_req;
        // Also runs in HOLD on the release cycle so a hold of N cycles costs exactly N.
        run     = ramping && !hold && !abort;
        clear   = !ramping || abort;
    end

    lock_rate_timer #(
        .TICKS_PER_CMIN (TICKS_PER_CMIN),
        .RAISE_DIV      (RAISE_DIV),
        .LOWER_DIV      (LOWER_DIV)
    ) u_rate_timer (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .clear     (clear),
        .div_sel   (dir_q),
        .cmin_tick (cmin_tick),
        .step      (step)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        level_d = level_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hold) begin
                    if (raise_req && !lower_req && (level_q < RAISE_TGT)) begin
                        state_d = RAISING;
                        dir_d   = 1'b0;
                    end else if (lower_req && !raise_req && (level_q > LOWER_TGT)) begin
                        state_d = LOWERING;
                        dir_d   = 1'b1;
                    end
                end
            end
            default: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (hold) begin
                    state_d = HOLD;
                end else begin
                    state_d = dir_q ? LOWERING : RAISING;
                    // step is a subset of cmin_tick; both must be present to move.
                    if (cmin_tick && step) begin
                        level_d = dir_q ? level_q - 1'b1 : level_q + 1'b1;
                        if (level_d == (dir_q ? LOWER_TGT : RAISE_TGT)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            level_q <= INIT_LVL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            level_q <= level_d;
            done_q  <= done_d;
        end
    end

`ifdef LOCK_WATER_ETA_EN
    logic [ETA_W-1:0] eta_q, eta_d;

    // remaining_steps*DIV - phase drops by exactly one on every cmin tick, including
    // the tick that steps the level, so a plain down-counter tracks it.
    always_comb begin
        eta_d = eta_q;
        if (state_d == IDLE) begin
            eta_d = '0;
        end else if (state_q == IDLE) begin
            eta_d = dir_d ? ETA_W'(32'(level_q - LOWER_TGT) * LOWER_DIV)
                          : ETA_W'(32'(RAISE_TGT - level_q) * RAISE_DIV);
        end else if (cmin_tick) begin
            eta_d = eta_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eta_q <= '0;
        end else begin
            eta_q <= eta_d;
        end
    end

    assign eta_cmin = eta_q;
`endif

    assign level    = level_q;
    assign done     = done_q;
    assign moving   = (state_q == RAISING) || (state_q == LOWERING);
    assign outer_ok = (level_q <= OUTER_OK_MAX);
    assign inner_ok = (level_q >= INNER_OK_MIN);

endmodule

// File: tb/tb_lock_water_level.sv
// Directed bench for lock_water_level with TICKS_PER_CMIN=2 (raise step every 32
// cycles, lower step every 28 cycles). Optional eta checks follow LOCK_WATER_ETA_EN.
module tb_lock_water_level;
    import lock_pkg::*;

    logic               clk;
    logic               reset;
    logic               raise_req;
    logic               lower_req;
    logic               hold;
    logic [LEVEL_W-1:0] level;
    logic               outer_ok;
    logic               inner_ok;
    logic               moving;
    logic               done;
`ifdef LOCK_WATER_ETA_EN
    logic [ETA_W-1:0]   eta_cmin;
`endif

    int tests;
    int fails;

    lock_water_level #(
        .TICKS_PER_CMIN (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raise_req (raise_req),
        .lower_req (lower_req),
        .hold      (hold),
        .level     (level),
        .outer_ok  (outer_ok),
        .inner_ok  (inner_ok),
        .moving    (moving),
        .done      (done)
`ifdef LOCK_WATER_ETA_EN
        ,
        .eta_cmin  (eta_cmin)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int rst, rai, low, hld;  // inputs held for n rising edges
        int n;
        int lvl, mov, dn, ook, iok, eta;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance n rising edges, then sit 1 time unit past the last one.
    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_eta(input string name, input int exp);
`ifdef LOCK_WATER_ETA_EN
        check(name, 32'(eta_cmin), exp);
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        raise_req = 1'b0;
        lower_req = 1'b0;
        hold = 1'b0;

        //            rst rai low hld   n   lvl mov dn ook iok eta
        vecs[0]  = '{ 1,  0,  0,  0,    1,  40, 0,  0, 1,  0,  0 };
        vecs[1]  = '{ 0,  1,  0,  0,    1,  40, 1,  0, 1,  0,  320 };  // enter RAISING
        vecs[2]  = '{ 0,  0,  0,  0,   31,  40, 1,  0, 1,  0,  305 };
        vecs[3]  = '{ 0,  0,  0,  0,    1,  41, 1,  0, 1,  0,  304 };  // first step at +32
        vecs[4]  = '{ 0,  0,  0,  0,   32,  42, 1,  0, 1,  0,  288 };
        vecs[5]  = '{ 0,  0,  0,  0,  544,  59, 1,  0, 0,  1,  16 };
        vecs[6]  = '{ 0,  0,  0,  0,   31,  59, 1,  0, 0,  1,  1 };
        vecs[7]  = '{ 0,  0,  0,  0,    1,  60, 0,  1, 0,  1,  0 };    // done at +640
        vecs[8]  = '{ 0,  0,  0,  0,    1,  60, 0,  0, 0,  1,  0 };
        vecs[9]  = '{ 0,  1,  0,  0,    2,  60, 0,  0, 0,  1,  0 };    // raise at target ignored
        vecs[10] = '{ 0,  0,  1,  0,    1,  60, 1,  0, 0,  1,  280 };  // enter LOWERING
        vecs[11] = '{ 0,  0,  0,  0,   28,  59, 1,  0, 0,  1,  266 };
        vecs[12] = '{ 0,  0,  0,  0,  447,  44, 1,  0, 0,  0,  43 };
        vecs[13] = '{ 0,  0,  0,  0,    1,  43, 1,  0, 1,  0,  42 };   // outer_ok rises
        vecs[14] = '{ 0,  0,  0,  0,   84,  40, 0,  1, 1,  0,  0 };    // done at +560
        vecs[15] = '{ 0,  0,  0,  0,    1,  40, 0,  0, 1,  0,  0 };

        #1;
        for (int i = 0; i < NV; i++) begin
            reset     = (vecs[i].rst != 0);
            raise_req = (vecs[i].rai != 0);
            lower_req = (vecs[i].low != 0);
            hold      = (vecs[i].hld != 0);
            go(vecs[i].n);
            check($sformatf("v%0d level", i), 32'(level), vecs[i].lvl);
            check($sformatf("v%0d moving", i), 32'(moving), vecs[i].mov);
            check($sformatf("v%0d done", i), 32'(done), vecs[i].dn);
            check($sformatf("v%0d outer_ok", i), 32'(outer_ok), vecs[i].ook);
            check($sformatf("v%0d inner_ok", i), 32'(inner_ok), vecs[i].iok);
            check_eta($sformatf("v%0d eta", i), vecs[i].eta);
        end
        raise_req = 1'b0;
        lower_req = 1'b0;

        // Hold for 100 cycles at phase 5 delays the first step by exactly 100 cycles.
        reset = 1'b1;
        go(1);
        reset = 1'b0;
        raise_req = 1'b1;
        go(1);
        raise_req = 1'b0;
        check_eta("hold entry eta", 320);
        go(10);
        check_eta("hold phase5 eta", 315);
        hold = 1'b1;
        go(50);
        check("hold mid level", 32'(level), 40);
        check("hold mid moving", 32'(moving), 0);
        go(50);
        check("hold end level", 32'(level), 40);
        check_eta("hold end eta", 315);
        hold = 1'b0;
        go(21);
        check("hold resume pre level", 32'(level), 40);
        check("hold resume moving", 32'(moving), 1);
        go(1);
        check("hold resume step level", 32'(level), 41);
        check_eta("hold resume eta", 304);

        // Single opposite request is ignored; both requests abort to IDLE.
        reset = 1'b1;
        go(1);
        reset = 1'b0;
        raise_req = 1'b1;
        go(1);
        raise_req = 1'b0;
        go(20);
        lower_req = 1'b1;
        go(5);
        lower_req = 1'b0;
        go(7);
        check("opposite req level", 32'(level), 41);
        check("opposite req moving", 32'(moving), 1);
        go(8);
        raise_req = 1'b1;
        lower_req = 1'b1;
        go(1);
        check("abort moving", 32'(moving), 0);
        check("abort level", 32'(level), 41);
        check("abort done", 32'(done), 0);
        check_eta("abort eta", 0);
        raise_req = 1'b0;
        lower_req = 1'b0;
        go(40);
        check("post abort level", 32'(level), 41);
        check("post abort moving", 32'(moving), 0);

        // Reset mid-ramp at level 50.
        reset = 1'b1;
        go(1);
        reset = 1'b0;
        raise_req = 1'b1;
        go(1);
        raise_req = 1'b0;
        go(320);
        check("pre reset level", 32'(level), 50);
        check("pre reset moving", 32'(moving), 1);
        reset = 1'b1;
        go(1);
        reset = 1'b0;
        check("mid reset level", 32'(level), 40);
        check("mid reset moving", 32'(moving), 0);
        check("mid reset done", 32'(done), 0);
        check("mid reset inner_ok", 32'(inner_ok), 0);
        check("mid reset outer_ok", 32'(outer_ok), 1);

        // Requests are ignored in IDLE while a door is open.
        hold = 1'b1;
        raise_req = 1'b1;
        go(3);
        check("idle hold moving", 32'(moving), 0);
        check("idle hold level", 32'(level), 40);
        hold = 1'b0;
        go(1);
        check("idle release moving", 32'(moving), 1);
        raise_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
